// File: rtl/arith_unit_pkg.sv
// Shared types and constants for the registered add/multiply unit.
// Operation encoding for sel, default operand/result widths.
package arith_unit_pkg;

  // Default operand width and the matching full-precision result width.
  localparam int OPW_DEF  = 2;
  localparam int RESW_DEF = 2 * OPW_DEF;

  // Operation select as seen on the sel input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_t;

endpackage

// File: rtl/arith_unit_mul.sv
// Combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// Shift-and-add array: one partial product per bit of b, gated by that bit,
// accumulated through a chain of 2*WIDTH-bit adders.
module arith_unit_mul
  import arith_unit_pkg::*;
#(
  parameter int WIDTH = OPW_DEF
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] p_o
);

  // a zero-extended once; each partial product is a shifted copy of it.
  logic [2*WIDTH-1:0]            a_ext;
  logic [WIDTH-1:0][2*WIDTH-1:0] pp;
  logic [WIDTH:0][2*WIDTH-1:0]   acc;

  assign a_ext  = {{WIDTH{1'b0}}, a_i};
  assign acc[0] = '0;

  // The full product fits in 2*WIDTH bits, so no accumulator stage can carry out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign pp[i]    = b_i[i] ? (a_ext << i) : '0;
    assign acc[i+1] = acc[i] + pp[i];
  end

  assign p_o = acc[WIDTH];

endmodule

// File: rtl/arith_unit.sv
// Registered unsigned add/multiply unit: y = A+B (sel=0) or A*B (sel=1).
// Latency 1 cycle, one operation per cycle, no handshake.
// Optional macro ARITH_UNIT_IN_REG_EN adds an input register stage
// (latency 2); those registers reset to 0 like the output register.
module arith_unit
  import arith_unit_pkg::*;
#(
  parameter int WIDTH = OPW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               sel,
  output logic [2*WIDTH-1:0] y
);

  // Operands as seen by the arithmetic (direct inputs or the input stage).
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             sel_s;

`ifdef ARITH_UNIT_IN_REG_EN
  logic [WIDTH-1:0] a_q, b_q;
  logic             sel_q;

  // Input stage: capture operands and op select every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      sel_q <= sel;
    end
  end

  assign a_s   = a_q;
  assign b_s   = b_q;
  assign sel_s = sel_q;
`else
  assign a_s   = A;
  assign b_s   = B;
  assign sel_s = sel;
`endif

  op_t              op_s;
  logic [2*WIDTH-1:0] sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] y_d, y_q;

  assign op_s = op_t'(sel_s);

  // Zero-extend before the add; at 2*WIDTH bits the sum cannot overflow.
  assign sum_s = {{WIDTH{1'b0}}, a_s} + {{WIDTH{1'b0}}, b_s};

  arith_unit_mul #(.WIDTH(WIDTH)) u_mul (
    .a_i (a_s),
    .b_i (b_s),
    .p_o (prod_s)
  );

  // Result select between sum and product.
  always_comb begin
    y_d = sum_s;
    if (op_s == OP_MUL) y_d = prod_s;
  end

  // Output register; reset clears y immediately and drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: tb/tb_arith_unit.sv
// Directed self-checking bench for arith_unit (default WIDTH=2).
// Expected latency follows ARITH_UNIT_IN_REG_EN when the bench is built with it.
module tb_arith_unit;

`ifdef ARITH_UNIT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] A, B;
  logic       sel;
  logic [3:0] y;

  int checks = 0;
  int errors = 0;

  arith_unit #(.WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .sel   (sel),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    A = 2'd3; B = 2'd3; sel = 1'b1; rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: y=%0d expected 0", y);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (y !== ((LAT == 1) ? 4'd9 : 4'd0)) begin
      errors++;
      $display("FAIL reset_release_edge1: y=%0d expected %0d", y, (LAT == 1) ? 9 : 0);
    end
    if (LAT == 2) begin
      tick();
      checks++;
      if (y !== 4'd9) begin
        errors++;
        $display("FAIL reset_release_edge2: y=%0d expected 9", y);
      end
    end
  endtask

  // All 16 operand pairs, add then multiply, one vector per cycle.
  task automatic test_sweep();
    for (int k = 0; k < 32 + LAT - 1; k++) begin
      if (k < 32) begin
        A   = 2'((k / 2) / 4);
        B   = 2'((k / 2) % 4);
        sel = 1'(k % 2);
      end
      tick();
      if (k - LAT + 1 >= 0) begin
        int j, ea, eb;
        logic [3:0] ex;
        j  = k - LAT + 1;
        ea = (j / 2) / 4;
        eb = (j / 2) % 4;
        ex = (j % 2 == 0) ? 4'(ea + eb) : 4'(ea * eb);
        checks++;
        if (y !== ex) begin
          errors++;
          $display("FAIL sweep A=%0d B=%0d sel=%0d: y=%0d expected %0d", ea, eb, j % 2, y, ex);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic [1:0] va [4] = '{2'd3, 2'd3, 2'd0, 2'd0};
    logic [1:0] vb [4] = '{2'd3, 2'd3, 2'd0, 2'd0};
    logic       vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] ex [4] = '{4'b0110, 4'b1001, 4'd0, 4'd0};
    for (int k = 0; k < 4 + LAT - 1; k++) begin
      if (k < 4) begin
        A = va[k]; B = vb[k]; sel = vs[k];
      end
      tick();
      if (k - LAT + 1 >= 0) begin
        checks++;
        if (y !== ex[k-LAT+1]) begin
          errors++;
          $display("FAIL extremes[%0d]: y=%0d expected %0d", k - LAT + 1, y, ex[k-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] ex [4] = '{4'd3, 4'd2, 4'd3, 4'd2};
    A = 2'd1; B = 2'd2;
    for (int k = 0; k < 4 + LAT - 1; k++) begin
      if (k < 4) sel = vs[k];
      tick();
      if (k - LAT + 1 >= 0) begin
        checks++;
        if (y !== ex[k-LAT+1]) begin
          errors++;
          $display("FAIL back_to_back[%0d]: y=%0d expected %0d", k - LAT + 1, y, ex[k-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    A = 2'd3; B = 2'd3; sel = 1'b1;
    for (int k = 0; k < LAT; k++) tick();
    checks++;
    if (y !== 4'd9) begin
      errors++;
      $display("FAIL mid_pre: y=%0d expected 9", y);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 4'd0) begin
      errors++;
      $display("FAIL mid_async: y=%0d expected 0", y);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (y !== 4'd0) begin
        errors++;
        $display("FAIL mid_hold[%0d]: y=%0d expected 0", k, y);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (y !== ((LAT == 1) ? 4'd9 : 4'd0)) begin
      errors++;
      $display("FAIL mid_release_edge1: y=%0d expected %0d", y, (LAT == 1) ? 9 : 0);
    end
    tick();
    checks++;
    if (y !== 4'd9) begin
      errors++;
      $display("FAIL mid_release_edge2: y=%0d expected 9", y);
    end
  endtask

  initial begin
    rst_n = 1'b1; A = '0; B = '0; sel = 1'b0;
    test_reset();
    test_sweep();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
